// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word type, fetch-stage state encoding and sequential PC step.
package cpu_types_pkg;

  localparam int unsigned WORD_W          = 32;
  localparam int unsigned PC_STEP_DEFAULT = 4;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  // Instruction addresses are word aligned; the two low bits of a target are dropped.
  function automatic word_t word_align(input word_t addr);
    return addr & ~word_t'(3);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: icache request/response, downstream control, IF/ID outputs.
interface fetch_stage_if;
  import cpu_types_pkg::*;

  logic  ihit;
  word_t iload;
  logic  imemREN;
  word_t imemaddr;
  logic  redirect;
  word_t redirect_pc;
  logic  stall;
  logic  halt;
  word_t instr_out;
  word_t pcout_out;
  logic  ifid_enable;
  logic  ifid_flush;
  logic  halted;

  modport master (
    input  ihit, iload, redirect, redirect_pc, stall, halt,
    output imemREN, imemaddr, instr_out, pcout_out, ifid_enable, ifid_flush, halted
  );

  modport slave (
    output ihit, iload, redirect, redirect_pc, stall, halt,
    input  imemREN, imemaddr, instr_out, pcout_out, ifid_enable, ifid_flush, halted
  );

endinterface

// File: rtl/fetch_stage_perf_counters.sv
// Saturating counters for delivered instructions and lost FETCH cycles.
module fetch_perf_counters
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  fetch_inc,
  input  logic  stall_inc,
  output word_t fetch_count,
  output word_t stall_count
);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (fetch_inc && (fetch_count != '1)) fetch_count <= fetch_count + word_t'(1);
      if (stall_inc && (stall_count != '1)) stall_count <= stall_count + word_t'(1);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, icache request, IF/ID strobes.
// Optional FETCH_PERF_CNT_EN adds fetch/stall performance counters.
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter word_t       PC_INIT = 32'h0000_0000,
  parameter int unsigned PC_STEP = PC_STEP_DEFAULT
) (
  input  logic          CLK,
  input  logic          nRST,
  fetch_stage_if.master fif
`ifdef FETCH_PERF_CNT_EN
  ,
  output word_t         fetch_count,
  output word_t         stall_count
`endif
);

  fetch_state_t state, state_n;
  word_t        pc, pc_n, pc_plus;
  logic         fetching;

  assign pc_plus  = pc + word_t'(PC_STEP);
  // Outputs are quiet while reset is held, even though state already reads FETCH.
  assign fetching = (state == FETCH) && nRST;

  // Next state / next PC; priority halt > redirect > stall > ihit.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    if (state == FETCH) begin
      if (fif.halt) begin
        state_n = HALTED;
      end else if (fif.redirect) begin
        pc_n = word_align(fif.redirect_pc);
      end else if (!fif.stall && fif.ihit) begin
        pc_n = pc_plus;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= FETCH;
      pc    <= PC_INIT;
    end else begin
      state <= state_n;
      pc    <= pc_n;
    end
  end

  assign fif.imemREN     = fetching;
  assign fif.imemaddr    = pc;
  assign fif.instr_out   = fif.iload;
  assign fif.pcout_out   = pc_plus;
  assign fif.ifid_enable = fetching && !fif.halt && !fif.redirect && !fif.stall && fif.ihit;
  assign fif.ifid_flush  = (state == HALTED) || (fetching && (fif.halt || fif.redirect));
  assign fif.halted      = (state == HALTED);

`ifdef FETCH_PERF_CNT_EN
  fetch_perf_counters u_perf (
    .CLK         (CLK),
    .nRST        (nRST),
    .fetch_inc   (fif.ifid_enable),
    .stall_inc   (fetching && !fif.ifid_enable && !fif.redirect),
    .fetch_count (fetch_count),
    .stall_count (stall_count)
  );
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: vector table plus reset-mid-miss sequence.
module tb_fetch_stage;
  import cpu_types_pkg::*;

  logic CLK;
  logic nRST;
  int   total;
  int   bad;

  fetch_stage_if fif ();

`ifdef FETCH_PERF_CNT_EN
  word_t fetch_count, stall_count;
`endif

  fetch_stage #(.PC_INIT(32'h0000_0000), .PC_STEP(4)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .fif  (fif)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count (fetch_count),
    .stall_count (stall_count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic  ihit, stall, redir, halt;
    word_t rpc;
    word_t addr, pcout;
    logic  ren, en, flush, halted;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(input logic ih, input logic st, input logic rd, input logic hl,
                              input word_t rpc, input word_t addr, input word_t pcout,
                              input logic ren, input logic en, input logic fl, input logic hd);
    vec_t v;
    v.ihit = ih; v.stall = st; v.redir = rd; v.halt = hl; v.rpc = rpc;
    v.addr = addr; v.pcout = pcout; v.ren = ren; v.en = en; v.flush = fl; v.halted = hd;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input word_t act, input word_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s [%0d]: got 0x%08h expected 0x%08h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic ih, input logic st, input logic rd, input logic hl, input word_t rpc);
    fif.ihit = ih; fif.stall = st; fif.redirect = rd; fif.halt = hl; fif.redirect_pc = rpc;
    fif.iload = word_t'($urandom);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    //            ih st rd hl rpc        addr   pcout  ren en fl hd
    vecs[0]  = mk(1, 0, 0, 0, 32'h0,   32'h0,   32'h4,   1, 1, 0, 0);
    vecs[1]  = mk(1, 0, 0, 0, 32'h0,   32'h4,   32'h8,   1, 1, 0, 0);
    vecs[2]  = mk(1, 0, 0, 0, 32'h0,   32'h8,   32'hC,   1, 1, 0, 0);
    vecs[3]  = mk(1, 0, 0, 0, 32'h0,   32'hC,   32'h10,  1, 1, 0, 0);
    vecs[4]  = mk(1, 0, 1, 0, 32'h8,   32'h10,  32'h14,  1, 0, 1, 0);
    vecs[5]  = mk(0, 0, 0, 0, 32'h0,   32'h8,   32'hC,   1, 0, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0, 32'h0,   32'h8,   32'hC,   1, 0, 0, 0);
    vecs[7]  = mk(0, 0, 0, 0, 32'h0,   32'h8,   32'hC,   1, 0, 0, 0);
    vecs[8]  = mk(1, 0, 0, 0, 32'h0,   32'h8,   32'hC,   1, 1, 0, 0);
    vecs[9]  = mk(0, 0, 0, 0, 32'h0,   32'hC,   32'h10,  1, 0, 0, 0);
    vecs[10] = mk(1, 1, 1, 0, 32'h103, 32'hC,   32'h10,  1, 0, 1, 0);
    vecs[11] = mk(1, 0, 0, 0, 32'h0,   32'h100, 32'h104, 1, 1, 0, 0);
    vecs[12] = mk(0, 0, 1, 0, 32'h22,  32'h104, 32'h108, 1, 0, 1, 0);
    vecs[13] = mk(1, 1, 0, 0, 32'h0,   32'h20,  32'h24,  1, 0, 0, 0);
    vecs[14] = mk(1, 1, 0, 0, 32'h0,   32'h20,  32'h24,  1, 0, 0, 0);
    vecs[15] = mk(1, 0, 0, 0, 32'h0,   32'h20,  32'h24,  1, 1, 0, 0);
    vecs[16] = mk(0, 0, 1, 0, 32'h40,  32'h24,  32'h28,  1, 0, 1, 0);
    vecs[17] = mk(1, 0, 1, 1, 32'h200, 32'h40,  32'h44,  1, 0, 1, 0);
    vecs[18] = mk(1, 0, 1, 0, 32'h300, 32'h40,  32'h0,   0, 0, 1, 1);
    vecs[19] = mk(1, 1, 0, 0, 32'h0,   32'h40,  32'h0,   0, 0, 1, 1);

    // Reset with ihit already high: nothing may be requested or enabled.
    nRST = 1'b0;
    drive(1, 0, 0, 0, 32'h0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_ren",    0, 32'(fif.imemREN),     32'h0);
    chk("rst_en",     0, 32'(fif.ifid_enable), 32'h0);
    chk("rst_flush",  0, 32'(fif.ifid_flush),  32'h0);
    chk("rst_halted", 0, 32'(fif.halted),      32'h0);
    chk("rst_addr",   0, fif.imemaddr,         32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_fcnt", 0, fetch_count, 32'h0);
    chk("rst_scnt", 0, stall_count, 32'h0);
`endif
    nRST = 1'b1;

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].ihit, vecs[i].stall, vecs[i].redir, vecs[i].halt, vecs[i].rpc);
      #1;
      chk("imemaddr",    i, fif.imemaddr,         vecs[i].addr);
      chk("imemREN",     i, 32'(fif.imemREN),     32'(vecs[i].ren));
      chk("ifid_enable", i, 32'(fif.ifid_enable), 32'(vecs[i].en));
      chk("ifid_flush",  i, 32'(fif.ifid_flush),  32'(vecs[i].flush));
      chk("halted",      i, 32'(fif.halted),      32'(vecs[i].halted));
      if (vecs[i].ren) begin
        chk("pcout_out", i, fif.pcout_out, vecs[i].pcout);
        chk("instr_out", i, fif.instr_out, fif.iload);
      end
      @(negedge CLK);
    end

`ifdef FETCH_PERF_CNT_EN
    chk("fetch_count", 20, fetch_count, 32'd7);
    chk("stall_count", 20, stall_count, 32'd6);
`endif

    // Leave HALTED through reset, then redirect to 0x80 and miss there.
    nRST = 1'b0;
    drive(0, 0, 0, 0, 32'h0);
    #1;
    chk("halt_rst_halted", 21, 32'(fif.halted), 32'h0);
    @(negedge CLK);
    nRST = 1'b1;
    drive(0, 0, 1, 0, 32'h80);
    #1;
    chk("redir80_addr", 22, fif.imemaddr, 32'h0);
    @(negedge CLK);
    drive(0, 0, 0, 0, 32'h0);
    #1;
    chk("miss_addr", 23, fif.imemaddr,         32'h80);
    chk("miss_en",   23, 32'(fif.ifid_enable), 32'h0);
    chk("miss_ren",  23, 32'(fif.imemREN),     32'h1);
    #2;
    // Asynchronous reset in the middle of a cycle, with a hit arriving.
    fif.ihit = 1'b1;
    nRST = 1'b0;
    #1;
    chk("mid_rst_addr",  24, fif.imemaddr,         32'h0);
    chk("mid_rst_ren",   24, 32'(fif.imemREN),     32'h0);
    chk("mid_rst_en",    24, 32'(fif.ifid_enable), 32'h0);
    chk("mid_rst_flush", 24, 32'(fif.ifid_flush),  32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("mid_rst_fcnt", 24, fetch_count, 32'h0);
    chk("mid_rst_scnt", 24, stall_count, 32'h0);
`endif
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    chk("post_rst_addr", 25, fif.imemaddr,         32'h0);
    chk("post_rst_ren",  25, 32'(fif.imemREN),     32'h1);
    chk("post_rst_en",   25, 32'(fif.ifid_enable), 32'h1);
    @(negedge CLK);
    #1;
    chk("post_rst_step", 26, fif.imemaddr, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
